parity_frame_receiver: RTL and testbench

//   Serial-in frame receiver: deserialises INPUT_WIDTH data bits plus one parity bit, LSB first.

---
 rtl/parity_frame_receiver_pkg.sv | 21 ++
 rtl/parity_frame_receiver_shift_reg.sv | 49 ++++
 rtl/parity_frame_receiver.sv | 124 ++++++++++++
 tb/tb_parity_frame_receiver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_receiver_pkg.sv
// Shared definitions for the serial parity frame receiver: state encoding and counter sizing.
package parity_frame_receiver_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SHIFT  = SHIFT,
        ST_PARITY = PARITY,
        ST_HOLD   = HOLD
    } state_t;

    // Bit counter must reach INPUT_WIDTH itself, hence width+1.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/parity_frame_receiver_shift_reg.sv
// LSB-first deserialising register with a running XOR of every bit shifted in.
module frame_shift_reg #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic                   bit_in,
    output logic [INPUT_WIDTH-1:0] shreg,
    output logic                   run_xor
);

    logic [INPUT_WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic                   xor_q, xor_d;

    // Shifting in at the MSB leaves the first received bit at bit 0 after a full frame.
    if (INPUT_WIDTH == 1) begin : g_single
        assign shifted = bit_in;
    end else begin : g_multi
        assign shifted = {bit_in, shreg_q[INPUT_WIDTH-1:1]};
    end

    always_comb begin
        shreg_d = shreg_q;
        xor_d   = xor_q;
        if (clr) begin
            shreg_d = '0;
            xor_d   = 1'b0;
        end else if (shift_en) begin
            shreg_d = shifted;
            xor_d   = xor_q ^ bit_in;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shreg_q <= '0;
            xor_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            xor_q   <= xor_d;
        end
    end

    assign shreg   = shreg_q;
    assign run_xor = xor_q;

endmodule

// File: rtl/parity_frame_receiver.sv
// Serial frame receiver: INPUT_WIDTH data bits + parity, LSB first, presented on valid/ready.
//   state  | meaning
//   IDLE   | waiting for frameStart
//   SHIFT  | collecting data bits
//   PARITY | waiting for the parity bit
//   HOLD   | word presented, waiting for dataReady
module parity_frame_receiver
    import parity_frame_receiver_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int PARITY_ODD  = 0
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   frameStart,
    input  logic                   serialIn,
    input  logic                   serialValid,
    output logic [INPUT_WIDTH-1:0] dataOut,
    output logic                   dataValid,
    input  logic                   dataReady,
    output logic                   parityError,
    output logic                   overrun
);

    localparam int               CW      = cnt_width(INPUT_WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(INPUT_WIDTH - 1);
    localparam logic             ODD_BIT = (PARITY_ODD != 0);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [INPUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q, overrun_d;
    logic                   clr, shift_en;
    logic [INPUT_WIDTH-1:0] shreg;
    logic                   run_xor;

    frame_shift_reg #(.INPUT_WIDTH(INPUT_WIDTH)) u_shift (
        .clock    (clock),
        .resetN   (resetN),
        .clr      (clr),
        .shift_en (shift_en),
        .bit_in   (serialIn),
        .shreg    (shreg),
        .run_xor  (run_xor)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        clr          = 1'b0;
        shift_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frameStart) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A restart wins over a coincident bit: that bit belongs to no frame.
                if (frameStart) begin
                    cnt_d = '0;
                    clr   = 1'b1;
                end else if (serialValid) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (frameStart) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end else if (serialValid) begin
                    parity_err_d = run_xor ^ serialIn ^ ODD_BIT;
                    data_out_d   = shreg;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dataReady) begin
                    if (frameStart) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        clr     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (serialValid || frameStart) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dataOut     = data_out_q;
    assign dataValid   = (state_q == ST_HOLD);
    assign parityError = parity_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Directed bench for parity_frame_receiver: even-parity W=8 instance plus an odd-parity twin.
module tb_parity_frame_receiver;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       frameStart = 1'b0;
    logic       serialIn = 1'b0;
    logic       serialValid = 1'b0;
    logic       dataReady = 1'b0;
    logic [7:0] dataOut, dataOut_o;
    logic       dataValid, dataValid_o;
    logic       parityError, parityError_o;
    logic       overrun, overrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    parity_frame_receiver #(.INPUT_WIDTH(8), .PARITY_ODD(0)) u_dut (
        .clock(clock), .resetN(resetN), .frameStart(frameStart), .serialIn(serialIn),
        .serialValid(serialValid), .dataOut(dataOut), .dataValid(dataValid),
        .dataReady(dataReady), .parityError(parityError), .overrun(overrun)
    );

    parity_frame_receiver #(.INPUT_WIDTH(8), .PARITY_ODD(1)) u_odd (
        .clock(clock), .resetN(resetN), .frameStart(frameStart), .serialIn(serialIn),
        .serialValid(serialValid), .dataOut(dataOut_o), .dataValid(dataValid_o),
        .dataReady(dataReady), .parityError(parityError_o), .overrun(overrun_o)
    );

    // Apply one cycle of inputs, clock it, settle 1 time unit past the edge.
    task automatic cyc(input logic fs, input logic sv, input logic si, input logic dr);
        frameStart = fs; serialValid = sv; serialIn = si; dataReady = dr;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        frameStart = 1'b0; serialValid = 1'b0; serialIn = 1'b0; dataReady = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] data);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, data[i], 1'b0);
    endtask

    task automatic accept();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle_inputs();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        n_cmp++; if (dataOut !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", dataOut); end
        n_cmp++; if ({dataValid, parityError, overrun} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {dataValid, parityError, overrun}); end
        @(negedge clock);
        resetN = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL rst_idle_sv: dataValid got %b want 0", dataValid); end
    endtask

    task automatic test_basic();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'h0D);
        n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL t1_early_valid: got %b want 0", dataValid); end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle_inputs();
        n_cmp++; if (dataValid !== 1'b1) begin n_bad++; $display("FAIL t1_valid: got %b want 1", dataValid); end
        n_cmp++; if (dataOut !== 8'h0D) begin n_bad++; $display("FAIL t1_data: got %h want 0d", dataOut); end
        n_cmp++; if (parityError !== 1'b0) begin n_bad++; $display("FAIL t1_perr: got %b want 0", parityError); end
        accept();
        n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL t1_handshake: dataValid got %b want 0", dataValid); end
        n_cmp++; if (dataOut !== 8'h0D) begin n_bad++; $display("FAIL t1_data_kept: got %h want 0d", dataOut); end
    endtask

    task automatic test_parity_error();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'h0D);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        n_cmp++; if (parityError !== 1'b1) begin n_bad++; $display("FAIL t2_even_perr: got %b want 1", parityError); end
        n_cmp++; if (parityError_o !== 1'b0) begin n_bad++; $display("FAIL t2_odd_perr: got %b want 0", parityError_o); end
        n_cmp++; if (dataOut_o !== 8'h0D) begin n_bad++; $display("FAIL t2_odd_data: got %h want 0d", dataOut_o); end
        accept();
    endtask

    task automatic test_overrun();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hA5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL t3_ovr_pre: got %b want 0", overrun); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, (i == 1 || i == 3), 1'b1, 1'b0);
            n_cmp++; if (dataOut !== 8'hA5 || dataValid !== 1'b1) begin n_bad++; $display("FAIL t3_hold_%0d: data %h valid %b want a5 1", i, dataOut, dataValid); end
        end
        idle_inputs();
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL t3_ovr_set: got %b want 1", overrun); end
        n_cmp++; if (parityError !== 1'b0) begin n_bad++; $display("FAIL t3_perr: got %b want 0", parityError); end
        accept();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL t3_ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'h3C);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (dataOut !== 8'h3C || dataValid !== 1'b1) begin n_bad++; $display("FAIL t4_first: data %h valid %b want 3c 1", dataOut, dataValid); end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL t4_accept: dataValid got %b want 0", dataValid); end
        send_bits(8'h81);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        n_cmp++; if (dataOut !== 8'h81 || dataValid !== 1'b1) begin n_bad++; $display("FAIL t4_second: data %h valid %b want 81 1", dataOut, dataValid); end
        n_cmp++; if (parityError !== 1'b0) begin n_bad++; $display("FAIL t4_perr: got %b want 0", parityError); end
        accept();
    endtask

    task automatic test_abort();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        // Restart coincides with a bit: that bit must be discarded.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        send_bits(8'h5A);
        n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL t5_no_early: dataValid got %b want 0", dataValid); end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        n_cmp++; if (dataOut !== 8'h5A || dataValid !== 1'b1) begin n_bad++; $display("FAIL t5_data: data %h valid %b want 5a 1", dataOut, dataValid); end
        n_cmp++; if (parityError !== 1'b0) begin n_bad++; $display("FAIL t5_perr: got %b want 0", parityError); end
        accept();
    endtask

    task automatic test_idle_start_with_bit();
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, (i < 4), 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle_inputs();
        n_cmp++; if (dataOut !== 8'h0F || dataValid !== 1'b1) begin n_bad++; $display("FAIL t7_data: data %h valid %b want 0f 1", dataOut, dataValid); end
        n_cmp++; if (parityError !== 1'b1) begin n_bad++; $display("FAIL t7_perr: got %b want 1", parityError); end
        accept();
    endtask

    task automatic test_reset_mid_frame();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++; if (dataOut !== 8'h00) begin n_bad++; $display("FAIL t6_async_data: got %h want 00", dataOut); end
        n_cmp++; if ({dataValid, parityError, overrun} !== 3'b000) begin n_bad++; $display("FAIL t6_async_flags: got %b want 000", {dataValid, parityError, overrun}); end
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (dataValid !== 1'b0) begin n_bad++; $display("FAIL t6_spurious: dataValid got %b want 0", dataValid); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'hC3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_inputs();
        n_cmp++; if (dataOut !== 8'hC3 || dataValid !== 1'b1) begin n_bad++; $display("FAIL t6_frame: data %h valid %b want c3 1", dataOut, dataValid); end
        n_cmp++; if (parityError !== 1'b0 || overrun !== 1'b0) begin n_bad++; $display("FAIL t6_flags: perr %b ovr %b want 0 0", parityError, overrun); end
        accept();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_error();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_idle_start_with_bit();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
